// File: rtl/wb_lfsr_sequencer.sv
// Wishbone master for the wb_lfsr slave: writes seed and tap mask, then
// assembles bytes from eight single-bit reads with a one-cycle valid strobe.
module wb_lfsr_sequencer #(
    parameter int unsigned TIMEOUT   = 15,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [7:0] i_seed,
    input  logic [7:0] i_taps,
    input  logic       i_rd_req,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_busy,
    output logic       o_cfg_done,
    output logic       o_err,
    output logic       o_wb_cyc,
    output logic       o_wb_stb,
    output logic       o_wb_we,
    output logic       o_wb_addr,
    output logic [7:0] o_wb_data,
    input  logic       i_wb_stall,
    input  logic       i_wb_ack,
    input  logic       i_wb_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_SEED,
        S_WR_TAPS,
        S_READY,
        S_RD_BIT
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic       req_q, req_d;
    logic [7:0] tcnt_q, tcnt_d;
    logic [2:0] bcnt_q, bcnt_d;
    logic [7:0] sh_q, sh_d;
    logic [7:0] seed_q, seed_d;
    logic [7:0] taps_q, taps_d;
    logic [7:0] byte_q, byte_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;

    logic       busy;
    logic       ack_ok;
    logic       tout;
    logic [7:0] sh_next;

    assign busy   = (state_q == S_WR_SEED) || (state_q == S_WR_TAPS) ||
                    (state_q == S_RD_BIT);
    // Acks are honoured only once the request phase is over.
    assign ack_ok = ~req_q & i_wb_ack;
    assign tout   = (tcnt_q == TO_LAST) && !ack_ok;

    assign sh_next = MSB_FIRST ? {sh_q[6:0], i_wb_data} : {i_wb_data, sh_q[7:1]};

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
            sh_q    <= '0;
            seed_q  <= '0;
            taps_q  <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            tcnt_q  <= tcnt_d;
            bcnt_q  <= bcnt_d;
            sh_q    <= sh_d;
            seed_q  <= seed_d;
            taps_q  <= taps_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        tcnt_d  = tcnt_q;
        bcnt_d  = bcnt_q;
        sh_d    = sh_q;
        seed_d  = seed_q;
        taps_d  = taps_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        err_d   = err_q;

        if (busy) begin
            if (req_q && !i_wb_stall) begin
                req_d = 1'b0;
            end
            if (tcnt_q != 8'hFF) begin
                tcnt_d = tcnt_q + 8'd1;
            end
        end

        case (state_q)
            S_IDLE, S_READY: begin
                if (i_start) begin
                    state_d = S_WR_SEED;
                    seed_d  = (i_seed == 8'h00) ? 8'h01 : i_seed;
                    taps_d  = i_taps;
                    err_d   = 1'b0;
                    req_d   = 1'b1;
                    tcnt_d  = '0;
                end else if (i_rd_req && (state_q == S_READY)) begin
                    state_d = S_RD_BIT;
                    req_d   = 1'b1;
                    tcnt_d  = '0;
                    bcnt_d  = '0;
                    sh_d    = '0;
                end
            end
            S_WR_SEED: begin
                if (ack_ok) begin
                    state_d = S_WR_TAPS;
                    req_d   = 1'b1;
                    tcnt_d  = '0;
                end else if (tout) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                end
            end
            S_WR_TAPS: begin
                if (ack_ok) begin
                    state_d = S_READY;
                    req_d   = 1'b0;
                end else if (tout) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                end
            end
            S_RD_BIT: begin
                if (ack_ok) begin
                    sh_d   = sh_next;
                    bcnt_d = bcnt_q + 3'd1;
                    if (bcnt_q == 3'd7) begin
                        state_d = S_READY;
                        req_d   = 1'b0;
                        byte_d  = sh_next;
                        valid_d = 1'b1;
                    end else begin
                        req_d  = 1'b1;
                        tcnt_d = '0;
                    end
                end else if (tout) begin
                    // Partial byte is dropped; o_byte keeps the last good value.
                    state_d = S_READY;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    assign o_busy       = busy;
    assign o_cfg_done   = (state_q == S_READY) || (state_q == S_RD_BIT);
    assign o_err        = err_q;
    assign o_byte       = byte_q;
    assign o_byte_valid = valid_q;
    assign o_wb_cyc     = busy;
    assign o_wb_stb     = busy & req_q;
    assign o_wb_we      = (state_q == S_WR_SEED) || (state_q == S_WR_TAPS);
    assign o_wb_addr    = (state_q == S_WR_TAPS);
    assign o_wb_data    = (state_q == S_WR_SEED) ? seed_q :
                          (state_q == S_WR_TAPS) ? taps_q : 8'h00;

endmodule

// File: tb/tb_wb_lfsr_sequencer.sv
// Directed bench for wb_lfsr_sequencer; two instances differ only in bit order.
module tb_wb_lfsr_sequencer;

    logic       i_clk;
    logic       i_reset;
    logic       i_start;
    logic [7:0] i_seed;
    logic [7:0] i_taps;
    logic       i_rd_req;
    logic       i_wb_stall;
    logic       i_wb_ack;
    logic       i_wb_data;

    logic [7:0] o_byte,    o2_byte;
    logic       o_byte_valid, o2_byte_valid;
    logic       o_busy,    o2_busy;
    logic       o_cfg_done, o2_cfg_done;
    logic       o_err,     o2_err;
    logic       o_wb_cyc,  o2_wb_cyc;
    logic       o_wb_stb,  o2_wb_stb;
    logic       o_wb_we,   o2_wb_we;
    logic       o_wb_addr, o2_wb_addr;
    logic [7:0] o_wb_data, o2_wb_data;

    int total;
    int bad;

    wb_lfsr_sequencer #(.TIMEOUT(15), .MSB_FIRST(1'b1)) u_msb (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_seed(i_seed),
        .i_taps(i_taps), .i_rd_req(i_rd_req), .o_byte(o_byte),
        .o_byte_valid(o_byte_valid), .o_busy(o_busy), .o_cfg_done(o_cfg_done),
        .o_err(o_err), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
        .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
        .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_data(i_wb_data)
    );

    wb_lfsr_sequencer #(.TIMEOUT(15), .MSB_FIRST(1'b0)) u_lsb (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_seed(i_seed),
        .i_taps(i_taps), .i_rd_req(i_rd_req), .o_byte(o2_byte),
        .o_byte_valid(o2_byte_valid), .o_busy(o2_busy), .o_cfg_done(o2_cfg_done),
        .o_err(o2_err), .o_wb_cyc(o2_wb_cyc), .o_wb_stb(o2_wb_stb),
        .o_wb_we(o2_wb_we), .o_wb_addr(o2_wb_addr), .o_wb_data(o2_wb_data),
        .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_data(i_wb_data)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Entered in the first stb cycle; stalls (with spurious acks), accepts, acks.
    task automatic serve(input int stalls, input logic we, input logic adr,
                         input logic [7:0] dat, input logic rbit);
        chk("stb_on", o_wb_stb, 1);
        chk("cyc_on", o_wb_cyc, 1);
        chk("we", o_wb_we, we);
        chk("addr", o_wb_addr, adr);
        chk("wdata", o_wb_data, dat);
        for (int i = 0; i < stalls; i++) begin
            i_wb_stall = 1'b1;
            i_wb_ack   = 1'b1;
            i_wb_data  = ~rbit;
            tick();
            chk("stb_stall", o_wb_stb, 1);
        end
        i_wb_stall = 1'b0;
        i_wb_ack   = 1'b0;
        tick();
        chk("stb_drop", o_wb_stb, 0);
        chk("cyc_wait", o_wb_cyc, 1);
        chk("valid_early", o_byte_valid, 0);
        i_wb_ack  = 1'b1;
        i_wb_data = rbit;
        tick();
        i_wb_ack  = 1'b0;
        i_wb_data = 1'b0;
    endtask

    logic [7:0] pat;

    initial begin
        total = 0;
        bad   = 0;
        i_reset = 1'b0; i_start = 1'b0; i_seed = '0; i_taps = '0;
        i_rd_req = 1'b0; i_wb_stall = 1'b0; i_wb_ack = 1'b0; i_wb_data = 1'b0;

        #2 i_reset = 1'b1;
        #1;
        chk("rst_outs", {o_byte, o_byte_valid, o_busy, o_cfg_done, o_err, o_wb_cyc,
                         o_wb_stb, o_wb_we, o_wb_addr, o_wb_data}, 0);
        chk("rst_outs2", {o2_byte, o2_byte_valid, o2_busy, o2_cfg_done, o2_err, o2_wb_cyc,
                          o2_wb_stb, o2_wb_we, o2_wb_addr, o2_wb_data}, 0);
        tick();
        tick();
        i_reset = 1'b0;
        tick();

        // Configuration A5/B8 under one cyc, cfg_done in cycle 5.
        i_start = 1'b1; i_seed = 8'hA5; i_taps = 8'hB8;
        tick();
        i_start = 1'b0; i_seed = 8'h00; i_taps = 8'h00;
        chk("busy_cfg", o_busy, 1);
        serve(0, 1'b1, 1'b0, 8'hA5, 1'b0);
        chk("cfg_mid", o_cfg_done, 0);
        serve(0, 1'b1, 1'b1, 8'hB8, 1'b0);
        chk("cfg_done_c5", o_cfg_done, 1);
        chk("cyc_ready", o_wb_cyc, 0);
        chk("busy_ready", o_busy, 0);

        // Read 1,0,1,1,0,0,1,0 -> B2 (MSB first), 4D (LSB first), valid in cycle 17.
        pat = 8'b10110010;
        i_rd_req = 1'b1;
        tick();
        i_rd_req = 1'b0;
        for (int b = 7; b >= 0; b--) serve(0, 1'b0, 1'b0, 8'h00, pat[b]);
        chk("valid_c17", o_byte_valid, 1);
        chk("byte_msb", o_byte, 8'hB2);
        chk("byte_lsb", o2_byte, 8'h4D);
        chk("valid_c17_2", o2_byte_valid, 1);
        tick();
        chk("valid_pulse", o_byte_valid, 0);
        chk("byte_hold", o_byte, 8'hB2);

        // Stall 3 on bit 0, bits 1,1,1,0,0,0,0,1 -> E1 / 87, valid in cycle 20.
        pat = 8'b11100001;
        i_rd_req = 1'b1;
        tick();
        i_rd_req = 1'b0;
        serve(3, 1'b0, 1'b0, 8'h00, pat[7]);
        for (int b = 6; b >= 0; b--) serve(0, 1'b0, 1'b0, 8'h00, pat[b]);
        chk("valid_c20", o_byte_valid, 1);
        chk("byte_stall_msb", o_byte, 8'hE1);
        chk("byte_stall_lsb", o2_byte, 8'h87);

        // Back-to-back request in the valid cycle; bit 2 then never acked.
        i_rd_req = 1'b1;
        tick();
        i_rd_req = 1'b0;
        serve(0, 1'b0, 1'b0, 8'h00, 1'b0);
        serve(0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("stb_bit2", o_wb_stb, 1);
        tick();
        for (int i = 0; i < 14; i++) begin
            chk("rd_to_cyc", o_wb_cyc, 1);
            chk("rd_to_err", o_err, 0);
            chk("rd_to_valid", o_byte_valid, 0);
            tick();
        end
        chk("rd_to_cycoff", o_wb_cyc, 0);
        chk("rd_to_stboff", o_wb_stb, 0);
        chk("rd_to_err_set", o_err, 1);
        chk("rd_to_ready", {o_cfg_done, o_busy}, 2'b10);
        chk("rd_to_byte", o_byte, 8'hE1);
        chk("rd_to_novalid", o_byte_valid, 0);
        tick();
        chk("rd_to_novalid2", o_byte_valid, 0);

        // Start and read together: start wins; zero seed written as 01; taps never acked.
        i_start = 1'b1; i_rd_req = 1'b1; i_seed = 8'h00; i_taps = 8'h3C;
        tick();
        i_start = 1'b0; i_rd_req = 1'b0; i_taps = 8'h00;
        chk("err_clr1", o_err, 0);
        chk("cfg_clr", o_cfg_done, 0);
        serve(0, 1'b1, 1'b0, 8'h01, 1'b0);
        chk("taps_stb", o_wb_stb, 1);
        chk("taps_addr", o_wb_addr, 1);
        chk("taps_data", o_wb_data, 8'h3C);
        tick();
        for (int i = 0; i < 14; i++) begin
            chk("wr_to_cyc", o_wb_cyc, 1);
            chk("wr_to_err", o_err, 0);
            tick();
        end
        chk("wr_to_err_set", o_err, 1);
        chk("wr_to_idle", {o_cfg_done, o_busy, o_wb_cyc, o_wb_stb}, 4'b0000);

        // Read request in IDLE is ignored.
        i_rd_req = 1'b1;
        tick();
        i_rd_req = 1'b0;
        chk("idle_rd_ign", {o_busy, o_wb_cyc, o_wb_stb}, 3'b000);
        tick();
        chk("idle_rd_ign2", o_wb_stb, 0);

        // Fresh configuration clears the error.
        i_start = 1'b1; i_seed = 8'h5B; i_taps = 8'h8E;
        tick();
        i_start = 1'b0; i_seed = 8'h00; i_taps = 8'h00;
        chk("err_clr2", o_err, 0);
        serve(0, 1'b1, 1'b0, 8'h5B, 1'b0);
        serve(0, 1'b1, 1'b1, 8'h8E, 1'b0);
        chk("cfg_done2", o_cfg_done, 1);

        // Reset during bit 3 of a read.
        i_rd_req = 1'b1;
        tick();
        i_rd_req = 1'b0;
        serve(0, 1'b0, 1'b0, 8'h00, 1'b1);
        serve(0, 1'b0, 1'b0, 8'h00, 1'b0);
        serve(0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("bit3_stb", o_wb_stb, 1);
        i_reset = 1'b1;
        #1;
        chk("mid_rst_bus", {o_wb_cyc, o_wb_stb}, 2'b00);
        chk("mid_rst_outs", {o_byte, o_byte_valid, o_busy, o_cfg_done, o_err, o_wb_cyc,
                             o_wb_stb, o_wb_we, o_wb_addr, o_wb_data}, 0);
        tick();
        i_reset = 1'b0;
        i_rd_req = 1'b1;
        tick();
        i_rd_req = 1'b0;
        chk("post_rst_rd", {o_busy, o_wb_cyc, o_wb_stb}, 3'b000);
        tick();
        chk("post_rst_rd2", {o_busy, o_wb_stb}, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_lfsr_sequencer.md
# wb_lfsr_sequencer

Wishbone master that configures and drains the `wb_lfsr` slave. On command it writes a seed and a tap mask into the LFSR. It then turns each byte request into eight single-bit Wishbone reads and delivers the assembled byte with a one-cycle valid strobe. It sits between on-chip control logic and `wb_lfsr`, and owns the Wishbone bus to that slave.

## Interface
- TIMEOUT, 15: max cycles per transaction, counted from first `o_wb_stb` to `i_wb_ack`; range 2..255.
- MSB_FIRST, 1: 1 = first bit read lands in `o_byte[7]`; 0 = first bit lands in `o_byte[0]`.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_start  in  1  begin configuration; accepted in IDLE or READY only.
- i_seed  in  8  seed, captured when `i_start` is accepted.
- i_taps  in  8  tap mask, captured when `i_start` is accepted.
- i_rd_req  in  1  request one byte; accepted in READY only.
- o_byte  out  8  last completed byte; holds its value between reads.
- o_byte_valid  out  1  one-cycle pulse when `o_byte` updates.
- o_busy  out  1  high in WR_SEED, WR_TAPS and RD_BIT.
- o_cfg_done  out  1  high while the LFSR is configured (READY and RD_BIT).
- o_err  out  1  sticky timeout flag.
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone master controls.
- o_wb_addr  out  1  0 = seed/state register, 1 = tap register.
- o_wb_data  out  8  write data.
- i_wb_stall, i_wb_ack  in  1 each  slave stall and acknowledge.
- i_wb_data  in  1  read data: the current LFSR output bit. Each read advances the LFSR.

## Operation
- States: IDLE, WR_SEED, WR_TAPS, READY, RD_BIT.
- Only one transaction is outstanding at a time. A transaction has two phases:
  - Request phase: `o_wb_stb` is held until an edge samples `stb=1 & stall=0`; stb then drops.
  - Ack wait: the block waits for `i_wb_ack`. An ack is honoured only in cycles after acceptance; an ack during the request phase is ignored.
- IDLE/READY + `i_start` → WR_SEED:
  - Capture seed and taps; clear `o_err` and `o_cfg_done`.
  - If `i_seed == 8'h00`, write `8'h01` instead (all-zero lock-up guard).
- WR_SEED: write, addr 0, captured seed. On ack → WR_TAPS.
- WR_TAPS: write, addr 1, captured taps. On ack → READY, with `o_cfg_done=1`.
- READY + `i_rd_req` → RD_BIT with the bit counter at 0.
- RD_BIT: read, addr 0, `we=0`, `o_wb_data=0`.
  - Each ack shifts `i_wb_data` into an 8-bit shift register in MSB_FIRST order and increments the counter.
  - On the 8th ack: load `o_byte`, pulse `o_byte_valid` in the next cycle, → READY.
- `o_wb_cyc` stays high from the first stb of the sequence to the final ack:
  - seed + taps form one cycle;
  - a byte read is one cycle of 8 reads.
  - `cyc` is low in IDLE and READY.
- Timeout: if the transaction counter reaches TIMEOUT without an ack:
  - drop `cyc`/`stb`, set `o_err`;
  - in WR_* → IDLE with `o_cfg_done=0`;
  - in RD_BIT → READY, partial byte discarded, `o_byte` unchanged, no valid pulse.
- Simultaneous `i_start` and `i_rd_req` in READY: start wins, the read is dropped.
- Requests while busy are ignored, not queued.

## Timing
- Reset (async, immediate): state IDLE; all outputs 0, including `o_byte`, `cyc` and `stb`. This applies mid-transaction too: the bus is released combinationally with reset.
- Commands are sampled at edge 0; `o_wb_stb` is high in cycle 1.
- Zero-stall slave acking one cycle after acceptance:
  - each transaction takes 2 cycles;
  - bit n: stb in cycle 1+2n, ack in cycle 2+2n;
  - `o_byte_valid` high in cycle 17 after `i_rd_req`;
  - `o_cfg_done` rises in cycle 5 after `i_start`.
- Each stall cycle delays the affected transaction by one cycle.
- Back-to-back: a new `i_rd_req` is accepted in the cycle `o_byte_valid` is high.
- The timeout counter resets at each new stb and saturates, so it does not wrap.

## Test plan
- Reset mid-read (assert `i_reset` during bit 3) → `cyc`/`stb` go low the same cycle; all outputs 0; state IDLE; a following `i_rd_req` is ignored.
- `i_start`, seed `8'hA5`, taps `8'hB8`, slave stall=0 and ack next cycle:
  - → writes (addr0, `A5`) then (addr1, `B8`) under one `cyc`;
  - `o_cfg_done=1` in cycle 5.
- `i_seed = 8'h00` → addr-0 write data is `8'h01`.
- Read with bits returned 1,0,1,1,0,0,1,0 and MSB_FIRST=1 → `o_byte=8'hB2`, single valid pulse in cycle 17.
  - With MSB_FIRST=0 → `8'h4D`.
- Stall held 3 cycles on bit 0 → stb held through the stall; valid arrives in cycle 20; bus traffic otherwise unchanged.
- No ack with TIMEOUT=15:
  - during WR_TAPS → `o_err=1`, IDLE, `o_cfg_done=0`;
  - during a read → READY, `o_byte` unchanged, no valid pulse.
  - In both cases the next `i_start` clears `o_err`.
